// File: rtl/gpr_mp.sv
// gpr_mp: multi-port general-purpose register file for the decode/writeback path.
// Two write ports (ALU and load writeback), RD_PORTS combinational read ports,
// a per-register busy scoreboard and a sequenced clear engine that zeroes the
// storage one register per cycle after reset or on request.
// Optional build macro GPR_MP_BYPASS_EN: reads forward same-cycle write data.
module gpr_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int REG_NUM  = 32,
  parameter int RD_PORTS = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clr_req,
  output logic                         ready,
  input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
  output logic [RD_PORTS*DATA_W-1:0]   rd_data,
  output logic [RD_PORTS-1:0]          rd_busy,
  input  logic                         we0_,
  input  logic [ADDR_W-1:0]            wr_addr0,
  input  logic [DATA_W-1:0]            wr_data0,
  input  logic                         we1_,
  input  logic [ADDR_W-1:0]            wr_addr1,
  input  logic [DATA_W-1:0]            wr_data1,
  input  logic                         iss_,
  input  logic [ADDR_W-1:0]            iss_addr
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(REG_NUM - 1);

  state_t                   state;
  logic [ADDR_W-1:0]        cnt;
  logic                     ready_q;
  logic [DATA_W-1:0]        regs [REG_NUM];
  logic [REG_NUM-1:0]       busy;

  logic                     run;
  logic                     wr0_ok;
  logic                     wr1_ok;
  logic                     iss_ok;

  // An address names real, writable storage: in range and not the hardwired zero register.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    addr_ok = (int'(a) < REG_NUM) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign run   = (state == ST_RUN);
  assign ready = ready_q;

  // Effective write/issue strobes: only in RUN, and a clear request drops them.
  assign wr0_ok = run && !clr_req && !we0_ && addr_ok(wr_addr0);
  assign wr1_ok = run && !clr_req && !we1_ && addr_ok(wr_addr1);
  assign iss_ok = run && !clr_req && !iss_ && addr_ok(iss_addr);

  // Sequencer: INIT walks cnt over every register, RUN serves traffic until a clear request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_INIT;
      cnt     <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (cnt == LAST_IDX) begin
            state   <= ST_RUN;
            cnt     <= '0;
            ready_q <= 1'b1;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        ST_RUN: begin
          if (clr_req) begin
            state   <= ST_INIT;
            cnt     <= '0;
            ready_q <= 1'b0;
          end
        end
        default: begin
          state   <= ST_INIT;
          cnt     <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Register storage: zeroed by the INIT walk, written by the two writeback ports in RUN.
  // NOTE: storage has no reset branch on purpose; the INIT sequence clears it, which keeps
  // the array free of a wide reset net and lets it map onto plain flops or RAM.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      regs[cnt] <= '0;
    end else begin
      // NOTE: both writes are non-blocking to the same array; on an address collision the
      // later statement (port 1) is the one that lands, which gives port 1 priority.
      if (wr0_ok) regs[wr_addr0] <= wr_data0;
      if (wr1_ok) regs[wr_addr1] <= wr_data1;
    end
  end

  // Scoreboard: writes retire a pending producer, an issue marks one; issue is applied last so it wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= '0;
    end else if (!run || clr_req) begin
      busy <= '0;
    end else begin
      if (wr0_ok) busy[wr_addr0] <= 1'b0;
      if (wr1_ok) busy[wr_addr1] <= 1'b0;
      if (iss_ok) busy[iss_addr] <= 1'b1;
    end
  end

  // Read ports: stored data and busy flag, zero outside RUN or for non-storage addresses.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned
    // and no latch is inferred.
    rd_data = '0;
    rd_busy = '0;
    if (run) begin
      for (int k = 0; k < RD_PORTS; k++) begin
        if (addr_ok(rd_addr[k*ADDR_W +: ADDR_W])) begin
          rd_data[k*DATA_W +: DATA_W] = regs[rd_addr[k*ADDR_W +: ADDR_W]];
          rd_busy[k]                  = busy[rd_addr[k*ADDR_W +: ADDR_W]];
`ifdef GPR_MP_BYPASS_EN
          if (wr1_ok && (wr_addr1 == rd_addr[k*ADDR_W +: ADDR_W])) begin
            rd_data[k*DATA_W +: DATA_W] = wr_data1;
            rd_busy[k]                  = 1'b0;
          end else if (wr0_ok && (wr_addr0 == rd_addr[k*ADDR_W +: ADDR_W])) begin
            rd_data[k*DATA_W +: DATA_W] = wr_data0;
            rd_busy[k]                  = 1'b0;
          end
`endif
        end
      end
    end
  end

endmodule

// File: doc/gpr_mp.md
Name: gpr_mp

Overview:
Parametrised multi-port general-purpose register file with a dual write port, N read ports, a per-register busy scoreboard and a sequenced clear engine. It sits in the CPU decode/writeback path. It supplies operands and hazard status to decode, and it accepts results from two writeback sources (ALU path, load path).

Parameters:
DATA_W, 32, register data width in bits
ADDR_W, 5, register address width
REG_NUM, 32, number of registers; must be <= 2**ADDR_W
RD_PORTS, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads as zero, ignores writes and never goes busy

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-low
clr_req  in  1  request full register clear (pulse, active-high)
ready  out  1  1 = RUN state; reads and writes are valid
rd_addr  in  RD_PORTS*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
rd_data  out  RD_PORTS*DATA_W  packed read data, combinational
rd_busy  out  RD_PORTS  per-port busy (pending write) flag, combinational
we0_  in  1  write port 0 enable, active-low
wr_addr0  in  ADDR_W  write port 0 address
wr_data0  in  DATA_W  write port 0 data
we1_  in  1  write port 1 enable, active-low
wr_addr1  in  ADDR_W  write port 1 address
wr_data1  in  DATA_W  write port 1 data
iss_  in  1  issue strobe, active-low; marks iss_addr busy
iss_addr  in  ADDR_W  destination register of the issued instruction

Behaviour:
- Reset (asynchronous, reset=0):
  - state=INIT, clear counter=0, all busy bits=0, ready=0.
  - Register storage itself is not reset; INIT zeroes it.
- FSM INIT:
  - Each cycle writes 0 to register[cnt], then cnt++.
  - After cnt==REG_NUM-1 is written, the next state is RUN. INIT lasts exactly REG_NUM cycles.
  - In INIT: ready=0, rd_data all 0, rd_busy all 0, write/issue inputs ignored.
- FSM RUN: ready=1.
  - clr_req=1 sampled in RUN -> INIT next cycle, cnt=0, all busy bits cleared. Writes and issues in that same cycle are dropped.
  - clr_req in INIT is ignored; the counter does not restart.
- Writes (RUN only):
  - Committed on the clk edge.
  - Both ports enabled with the same address -> port 1 data is stored and port 0 is discarded.
  - Address >= REG_NUM is ignored.
  - With ZERO_REG=1, writes to address 0 are ignored.
- Reads:
  - Combinational.
  - Address >= REG_NUM returns 0.
  - With ZERO_REG=1, address 0 returns 0.
  - Bypass of same-cycle writes: see Optional Feature.
- Scoreboard:
  - busy[a] is set on the edge where iss_=0 and iss_addr=a.
  - busy[a] is cleared on the edge where a write port writes a.
  - Set and clear of the same address in the same cycle -> the set wins; busy stays 1 because a new producer was issued.
  - rd_busy[k] = busy[rd_addr_k], forced to 0 when the bypass applies to port k in that cycle.
  - ZERO_REG=1: address 0 never becomes busy.
- Reset mid-INIT or mid-RUN restarts INIT from cnt=0.

Optional Feature:
Macro GPR_MP_BYPASS_EN.
- Defined:
  - A read whose address matches an enabled write in the same cycle returns the write data.
  - Port 1 match takes priority over port 0.
  - rd_busy for that port is 0.
- Undefined:
  - Reads always return stored contents (read-before-write).
  - rd_busy reflects the stored busy bit only.
- The zero-register and out-of-range rules apply in both builds.

Test Plan:
- Release reset with default parameters -> ready=0 for 32 cycles, then 1. rd_data for every address reads 0x00000000.
- RUN: we0_=0, wr_addr0=5, wr_data0=0xDEADBEEF; next cycle rd_addr port0=5 -> rd_data=0xDEADBEEF. Write to r0 with 0x1234 -> r0 still reads 0.
- Same cycle: we0_=0 and we1_=0, both to r7, data 0x11111111 / 0x22222222 -> r7 reads 0x22222222 afterwards. With GPR_MP_BYPASS_EN, in that cycle a read of r7 returns 0x22222222; without the macro it returns the old value.
- Scoreboard sequence:
  - iss_=0, iss_addr=9 -> rd_busy=1 for r9 the next cycle.
  - Write to r9 -> busy clears after the edge.
  - Issue to r9 and write to r9 in the same cycle -> busy remains 1.
- Clear mid-operation: with r3=0xA5A5A5A5 and r9 busy, pulse clr_req:
  - ready drops for 32 cycles; a write issued during INIT is ignored.
  - After INIT, r3=0 and r9 is not busy.
  - Assert reset during INIT at cnt=10 -> INIT restarts and lasts a full 32 cycles.
